interrupt_ack_sequencer: RTL and testbench

// - Sequences the 8259A in-service register (ISR) through the CPU INTA cycle and EOI commands.
// - Picks the winning request with rotating priority and raises INT.
// - On INTA it sets the ISR bit, clears the request, and drives the vector/CALL bytes.
// - Handles AEOI, specific/non-specific EOI and rotation; sits between the IRR/IMR and the data bus buffer.

---
 rtl/pic_pkg.sv | 63 ++++++
 rtl/interrupt_ack_sequencer_if.sv | 39 +++
 rtl/pic_priority_resolver.sv | 14 +
 rtl/interrupt_ack_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_interrupt_ack_sequencer.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/pic_pkg.sv
// Shared types, constants and priority helpers for the 8259A in-service sequencer.
package pic_pkg;

  localparam int unsigned NUM_LEVELS = 8;
  localparam int unsigned LVL_W      = 3;

  localparam logic [NUM_LEVELS-1:0] CALL_OPCODE  = 8'hCD;
  localparam logic [NUM_LEVELS-1:0] RESET_LOWEST = 8'h80;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_P1,
    ST_W2,
    ST_P2,
    ST_W3,
    ST_P3
  } state_e;

  // Index of the set bit in a one-hot vector (0 when empty).
  function automatic logic [LVL_W-1:0] onehot_to_level(input logic [NUM_LEVELS-1:0] oh);
    logic [LVL_W-1:0] lvl;
    lvl = '0;
    for (int i = 0; i < NUM_LEVELS; i++) begin
      if (oh[i]) lvl = LVL_W'(i);
    end
    return lvl;
  endfunction

  // One-hot of the highest-priority set bit; the level after last_serviced ranks first.
  function automatic logic [NUM_LEVELS-1:0] rotate_priority(input logic [NUM_LEVELS-1:0] mask,
                                                            input logic [NUM_LEVELS-1:0] last_serviced);
    logic [NUM_LEVELS-1:0] grant;
    logic [LVL_W-1:0]      base;
    logic [LVL_W-1:0]      idx;
    grant = '0;
    base  = onehot_to_level(last_serviced);
    // Walk from lowest to highest priority so the highest hit is written last.
    for (int k = NUM_LEVELS; k >= 1; k--) begin
      idx = base + LVL_W'(k);
      if (mask[idx]) grant = NUM_LEVELS'(1) << idx;
    end
    return grant;
  endfunction

  // Levels ranking strictly above the one-hot top level; all levels when top is empty.
  function automatic logic [NUM_LEVELS-1:0] higher_priority_mask(input logic [NUM_LEVELS-1:0] top,
                                                                 input logic [NUM_LEVELS-1:0] last_serviced);
    logic [NUM_LEVELS-1:0] mask;
    logic [LVL_W-1:0]      base;
    logic [LVL_W-1:0]      idx;
    logic                  hit;
    mask = '0;
    hit  = 1'b0;
    base = onehot_to_level(last_serviced);
    for (int k = 1; k <= NUM_LEVELS; k++) begin
      idx = base + LVL_W'(k);
      if (top[idx]) hit = 1'b1;
      if (!hit) mask[idx] = 1'b1;
    end
    return mask;
  endfunction

endpackage

// File: rtl/interrupt_ack_sequencer_if.sv
// Request/acknowledge/EOI bundle between the PIC register file, the CPU and the sequencer.
interface interrupt_ack_sequencer_if;

  logic [7:0] irr;
  logic [7:0] imr;
  logic       inta_n;
  logic       mode_8086;
  logic       aeoi;
  logic       rotate_in_aeoi;
  logic       special_mask_mode;
  logic [4:0] vector_base;
  logic       adi;
  logic [2:0] addr_lo;
  logic [7:0] addr_hi;
  logic       eoi_valid;
  logic       eoi_specific;
  logic [2:0] eoi_level;
  logic       rotate_on_eoi;

  logic       int_out;
  logic [7:0] in_service_register;
  logic [7:0] last_serviced;
  logic [7:0] irr_clear;
  logic [7:0] data_out;
  logic       data_oe;

  modport master (
    output irr, imr, inta_n, mode_8086, aeoi, rotate_in_aeoi, special_mask_mode,
           vector_base, adi, addr_lo, addr_hi, eoi_valid, eoi_specific, eoi_level, rotate_on_eoi,
    input  int_out, in_service_register, last_serviced, irr_clear, data_out, data_oe
  );

  modport slave (
    input  irr, imr, inta_n, mode_8086, aeoi, rotate_in_aeoi, special_mask_mode,
           vector_base, adi, addr_lo, addr_hi, eoi_valid, eoi_specific, eoi_level, rotate_on_eoi,
    output int_out, in_service_register, last_serviced, irr_clear, data_out, data_oe
  );

endinterface

// File: rtl/pic_priority_resolver.sv
// Combinational rotating-priority resolver: one-hot grant of the highest-priority request.
module pic_priority_resolver
  import pic_pkg::*;
(
  input  logic [NUM_LEVELS-1:0] req,
  input  logic [NUM_LEVELS-1:0] last_serviced,
  output logic [NUM_LEVELS-1:0] grant_c,
  output logic                  valid_c
);

  assign grant_c = rotate_priority(req, last_serviced);
  assign valid_c = |req;

endmodule

// File: rtl/interrupt_ack_sequencer.sv
// 8259A INTA/EOI sequencer: picks the winning IR level, runs the INTA byte
// sequence and maintains the ISR and rotating priority.
module interrupt_ack_sequencer
  import pic_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  interrupt_ack_sequencer_if.slave   bus
);

  state_e                state_q, state_d;
  logic                  inta_n_q;
  logic                  int_out_q, int_out_d;
  logic [NUM_LEVELS-1:0] isr_q, isr_d;
  logic [NUM_LEVELS-1:0] ls_q, ls_d;
  logic [NUM_LEVELS-1:0] irr_clear_q, irr_clear_d;
  logic [7:0]            data_out_q, data_out_d;
  logic                  data_oe_q, data_oe_d;
  logic [LVL_W-1:0]      lvl_q, lvl_d;
  logic                  spurious_q, spurious_d;

  logic                  fall, rise;
  logic [NUM_LEVELS-1:0] cand_base, cand;
  logic [NUM_LEVELS-1:0] isr_top, win;
  logic                  isr_any, win_any;
  logic [NUM_LEVELS-1:0] eoi_target, eoi_clear;
  logic [NUM_LEVELS-1:0] isr_set, aeoi_clear;
  logic                  final_rise;
  logic [7:0]            vector_byte;

  assign fall = inta_n_q & ~bus.inta_n;
  assign rise = ~inta_n_q & bus.inta_n;

  // Highest-priority in-service level: nesting limit and non-specific EOI target.
  pic_priority_resolver u_isr_res (
    .req           (isr_q),
    .last_serviced (ls_q),
    .grant_c       (isr_top),
    .valid_c       (isr_any)
  );

  assign cand_base = bus.irr & ~bus.imr;
  assign cand      = bus.special_mask_mode ? (cand_base & ~isr_q)
                   : isr_any               ? (cand_base & higher_priority_mask(isr_top, ls_q))
                   :                         cand_base;

  pic_priority_resolver u_win_res (
    .req           (cand),
    .last_serviced (ls_q),
    .grant_c       (win),
    .valid_c       (win_any)
  );

  assign eoi_target = bus.eoi_specific ? (NUM_LEVELS'(1) << bus.eoi_level) : isr_top;
  assign eoi_clear  = bus.eoi_valid ? (eoi_target & isr_q) : '0;

  assign vector_byte = bus.mode_8086 ? {bus.vector_base, lvl_q}
                     : bus.adi       ? {bus.addr_lo, lvl_q, 2'b00}
                     :                 {bus.addr_lo[2:1], lvl_q, 3'b000};

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    int_out_d   = 1'b0;
    irr_clear_d = '0;
    data_out_d  = data_out_q;
    data_oe_d   = data_oe_q;
    lvl_d       = lvl_q;
    spurious_d  = spurious_q;
    ls_d        = ls_q;
    isr_set     = '0;
    aeoi_clear  = '0;
    final_rise  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        int_out_d = win_any;
        if (fall) begin
          state_d   = ST_P1;
          int_out_d = 1'b0;
          if (win_any) begin
            lvl_d       = onehot_to_level(win);
            spurious_d  = 1'b0;
            isr_set     = win;
            irr_clear_d = win;
          end else begin
            lvl_d      = LVL_W'(7);
            spurious_d = 1'b1;
          end
          if (bus.mode_8086) begin
            data_oe_d = 1'b0;
          end else begin
            data_out_d = CALL_OPCODE;
            data_oe_d  = 1'b1;
          end
        end
      end
      ST_P1: begin
        if (rise) begin
          state_d   = ST_W2;
          data_oe_d = 1'b0;
        end
      end
      ST_W2: begin
        if (fall) begin
          state_d    = ST_P2;
          data_out_d = vector_byte;
          data_oe_d  = 1'b1;
        end
      end
      ST_P2: begin
        if (rise) begin
          data_oe_d = 1'b0;
          if (bus.mode_8086) begin
            state_d    = ST_IDLE;
            final_rise = 1'b1;
          end else begin
            state_d = ST_W3;
          end
        end
      end
      ST_W3: begin
        if (fall) begin
          state_d    = ST_P3;
          data_out_d = bus.addr_hi;
          data_oe_d  = 1'b1;
        end
      end
      ST_P3: begin
        if (rise) begin
          state_d    = ST_IDLE;
          data_oe_d  = 1'b0;
          final_rise = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A spurious sequence never set an ISR bit, so AEOI has nothing to retire.
    if (final_rise && bus.aeoi && !spurious_q) begin
      aeoi_clear = NUM_LEVELS'(1) << lvl_q;
      if (bus.rotate_in_aeoi) ls_d = aeoi_clear;
    end
    if ((|eoi_clear) && bus.rotate_on_eoi) ls_d = eoi_clear;

    isr_d = (isr_q & ~(eoi_clear | aeoi_clear)) | isr_set;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      inta_n_q    <= 1'b1;
      int_out_q   <= 1'b0;
      isr_q       <= '0;
      ls_q        <= RESET_LOWEST;
      irr_clear_q <= '0;
      data_out_q  <= '0;
      data_oe_q   <= 1'b0;
      lvl_q       <= '0;
      spurious_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      inta_n_q    <= bus.inta_n;
      int_out_q   <= int_out_d;
      isr_q       <= isr_d;
      ls_q        <= ls_d;
      irr_clear_q <= irr_clear_d;
      data_out_q  <= data_out_d;
      data_oe_q   <= data_oe_d;
      lvl_q       <= lvl_d;
      spurious_q  <= spurious_d;
    end
  end

  assign bus.int_out             = int_out_q;
  assign bus.in_service_register = isr_q;
  assign bus.last_serviced       = ls_q;
  assign bus.irr_clear           = irr_clear_q;
  assign bus.data_out            = data_out_q;
  assign bus.data_oe             = data_oe_q;

endmodule

// File: tb/tb_interrupt_ack_sequencer.sv
// Scoreboard bench for interrupt_ack_sequencer: directed INTA/EOI scenarios with
// expected bus bytes and IRR clear pulses queued and checked by a monitor.
module tb_interrupt_ack_sequencer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  interrupt_ack_sequencer_if dif();

  interrupt_ack_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (dif.slave)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] byte_q[$];
  logic [7:0] clr_q[$];
  logic       oe_prev = 1'b0;

  task automatic cycle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check8(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic pulse();
    dif.inta_n = 1'b0;
    cycle(2);
    dif.inta_n = 1'b1;
    cycle(2);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle(2);
    reset = 1'b0;
    cycle(1);
  endtask

  // Monitor: every IRR clear pulse and every new data byte must match the queue head.
  always @(negedge clk) begin
    logic [7:0] e;
    if (reset) begin
      oe_prev = 1'b0;
    end else begin
      if (dif.irr_clear != 8'h00) begin
        checks++;
        if (clr_q.size() == 0) begin
          errors++;
          $display("FAIL irr_clear_unexpected: got %h, expected none", dif.irr_clear);
        end else begin
          e = clr_q.pop_front();
          if (dif.irr_clear !== e) begin
            errors++;
            $display("FAIL irr_clear: got %h, expected %h", dif.irr_clear, e);
          end
        end
      end
      if (dif.data_oe && !oe_prev) begin
        checks++;
        if (byte_q.size() == 0) begin
          errors++;
          $display("FAIL data_byte_unexpected: got %h, expected none", dif.data_out);
        end else begin
          e = byte_q.pop_front();
          if (dif.data_out !== e) begin
            errors++;
            $display("FAIL data_byte: got %h, expected %h", dif.data_out, e);
          end
        end
      end
      oe_prev = dif.data_oe;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    dif.irr = 8'h00;  dif.imr = 8'h00;  dif.inta_n = 1'b1;
    dif.mode_8086 = 1'b1;  dif.aeoi = 1'b0;  dif.rotate_in_aeoi = 1'b0;
    dif.special_mask_mode = 1'b0;  dif.vector_base = 5'd1;  dif.adi = 1'b1;
    dif.addr_lo = 3'd0;  dif.addr_hi = 8'h00;  dif.eoi_valid = 1'b0;
    dif.eoi_specific = 1'b0;  dif.eoi_level = 3'd0;  dif.rotate_on_eoi = 1'b0;

    reset = 1'b1;
    cycle(2);
    check8("reset_int_out",   {7'd0, dif.int_out}, 8'h00);
    check8("reset_isr",       dif.in_service_register, 8'h00);
    check8("reset_last_serv", dif.last_serviced, 8'h80);
    check8("reset_irr_clear", dif.irr_clear, 8'h00);
    check8("reset_data_out",  dif.data_out, 8'h00);
    check8("reset_data_oe",   {7'd0, dif.data_oe}, 8'h00);
    reset = 1'b0;
    cycle(1);

    // 8086 sequence on IR5
    dif.irr = 8'h20;
    cycle(1);
    check8("t1_int_out", {7'd0, dif.int_out}, 8'h01);
    clr_q.push_back(8'h20);
    byte_q.push_back(8'h0D);
    dif.inta_n = 1'b0;
    cycle(1);
    check8("t1_isr_p1", dif.in_service_register, 8'h20);
    check8("t1_int_drop", {7'd0, dif.int_out}, 8'h00);
    dif.irr = 8'h00;
    cycle(1);
    dif.inta_n = 1'b1;
    cycle(2);
    check8("t1_oe_w2", {7'd0, dif.data_oe}, 8'h00);
    pulse();
    check8("t1_isr_end", dif.in_service_register, 8'h20);

    // Nest IR1 over IR5, then non-specific EOI with rotation
    dif.irr = 8'h02;
    cycle(1);
    check8("t3_int_nested", {7'd0, dif.int_out}, 8'h01);
    clr_q.push_back(8'h02);
    byte_q.push_back(8'h09);
    pulse();
    dif.irr = 8'h00;
    pulse();
    check8("t3_isr_22", dif.in_service_register, 8'h22);
    dif.eoi_valid = 1'b1;  dif.eoi_specific = 1'b0;  dif.rotate_on_eoi = 1'b1;
    cycle(1);
    dif.eoi_valid = 1'b0;  dif.rotate_on_eoi = 1'b0;
    check8("t3_isr_eoi", dif.in_service_register, 8'h20);
    check8("t3_ls_rot", dif.last_serviced, 8'h02);
    dif.irr = 8'h05;
    cycle(1);
    check8("t3_int_ir2", {7'd0, dif.int_out}, 8'h01);
    clr_q.push_back(8'h04);
    byte_q.push_back(8'h0A);
    pulse();
    dif.irr = 8'h01;
    pulse();
    check8("t3_isr_24", dif.in_service_register, 8'h24);
    cycle(2);
    check8("t3_ir0_blocked", {7'd0, dif.int_out}, 8'h00);
    dif.irr = 8'h00;
    dif.eoi_valid = 1'b1;  dif.eoi_specific = 1'b1;  dif.eoi_level = 3'd2;
    cycle(1);
    check8("t3_spec_eoi2", dif.in_service_register, 8'h20);
    dif.eoi_level = 3'd5;
    cycle(1);
    dif.eoi_valid = 1'b0;
    check8("t3_spec_eoi5", dif.in_service_register, 8'h00);
    check8("t3_ls_hold", dif.last_serviced, 8'h02);

    // 8080 sequences, adi = 1 then adi = 0
    do_reset();
    dif.mode_8086 = 1'b0;  dif.adi = 1'b1;  dif.addr_lo = 3'b101;  dif.addr_hi = 8'h12;
    dif.irr = 8'h04;
    cycle(1);
    clr_q.push_back(8'h04);
    byte_q.push_back(8'hCD);  byte_q.push_back(8'hA8);  byte_q.push_back(8'h12);
    pulse();
    dif.irr = 8'h00;
    check8("t2_oe_w2", {7'd0, dif.data_oe}, 8'h00);
    pulse();
    check8("t2_oe_w3", {7'd0, dif.data_oe}, 8'h00);
    pulse();
    check8("t2_isr", dif.in_service_register, 8'h04);
    dif.eoi_valid = 1'b1;  dif.eoi_specific = 1'b1;  dif.eoi_level = 3'd2;
    cycle(1);
    dif.eoi_valid = 1'b0;
    dif.adi = 1'b0;
    dif.irr = 8'h08;
    cycle(1);
    clr_q.push_back(8'h08);
    byte_q.push_back(8'hCD);  byte_q.push_back(8'h98);  byte_q.push_back(8'h12);
    pulse();
    dif.irr = 8'h00;
    pulse();
    pulse();
    check8("t2b_isr", dif.in_service_register, 8'h08);

    // AEOI with rotation on IR0
    do_reset();
    dif.mode_8086 = 1'b1;  dif.aeoi = 1'b1;  dif.rotate_in_aeoi = 1'b1;
    dif.irr = 8'h01;
    cycle(1);
    clr_q.push_back(8'h01);
    byte_q.push_back(8'h08);
    pulse();
    dif.irr = 8'h00;
    check8("t4_isr_mid", dif.in_service_register, 8'h01);
    pulse();
    check8("t4_isr_end", dif.in_service_register, 8'h00);
    check8("t4_ls", dif.last_serviced, 8'h01);
    dif.aeoi = 1'b0;  dif.rotate_in_aeoi = 1'b0;

    // Spurious: request withdrawn before the first INTA
    do_reset();
    dif.irr = 8'h08;
    cycle(1);
    check8("t5_int_up", {7'd0, dif.int_out}, 8'h01);
    dif.irr = 8'h00;
    cycle(2);
    check8("t5_int_down", {7'd0, dif.int_out}, 8'h00);
    byte_q.push_back(8'h0F);
    pulse();
    pulse();
    check8("t5_isr", dif.in_service_register, 8'h00);

    // Reset while waiting for the second INTA
    dif.irr = 8'h10;
    cycle(1);
    clr_q.push_back(8'h10);
    pulse();
    check8("t6_isr_w2", dif.in_service_register, 8'h10);
    reset = 1'b1;
    #1;
    check8("t6_rst_isr", dif.in_service_register, 8'h00);
    check8("t6_rst_ls", dif.last_serviced, 8'h80);
    check8("t6_rst_oe", {7'd0, dif.data_oe}, 8'h00);
    check8("t6_rst_int", {7'd0, dif.int_out}, 8'h00);
    cycle(2);
    reset = 1'b0;
    cycle(1);
    clr_q.push_back(8'h10);
    byte_q.push_back(8'h0C);
    pulse();
    dif.irr = 8'h00;
    check8("t6_fresh_p1_isr", dif.in_service_register, 8'h10);
    pulse();

    // Special mask mode lets a lower level through while IR4 is in service
    dif.irr = 8'h20;
    cycle(2);
    check8("smm_off_blocked", {7'd0, dif.int_out}, 8'h00);
    dif.special_mask_mode = 1'b1;
    cycle(2);
    check8("smm_on_int", {7'd0, dif.int_out}, 8'h01);
    dif.special_mask_mode = 1'b0;
    dif.irr = 8'h00;
    cycle(3);

    checks++;
    if (byte_q.size() != 0) begin
      errors++;
      $display("FAIL byte_queue_drain: got %0d pending, expected 0", byte_q.size());
    end
    checks++;
    if (clr_q.size() != 0) begin
      errors++;
      $display("FAIL clear_queue_drain: got %0d pending, expected 0", clr_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
